ej32_dstack: RTL

Parametrised data stack for the eJ32 arithmetic unit, replacing the fixed 32-deep, 32-bit stack. TOS and NOS live in registers and the spill entries in a register array. It adds a depth counter, full/empty status, sticky overflow/underflow flags, a combined pop-and-replace ALU op, and a multi-cycle PICK for reading any stack position. The arithmetic unit drives one stack op per cycle and reads `t_o`/`s_o` as its operands.

---
 rtl/ej32_pkg.sv | 21 ++
 rtl/ej32_dstack.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ej32_pkg.sv
// ej32_pkg -- shared types for the eJ32 data stack.
//   dstack_op_t : stack operation code driven by the arithmetic unit
//   ds_state_t  : data stack FSM state (IDLE, or RD while a deep PICK reads)
package ej32_pkg;

    typedef enum logic [2:0] {
        sNOP  = 3'd0,
        sPUSH = 3'd1,
        sPOP  = 3'd2,
        sSWAP = 3'd3,
        sREPL = 3'd4,
        sALU  = 3'd5,
        sPICK = 3'd6
    } dstack_op_t;

    typedef enum logic {
        DS_IDLE = 1'b0,
        DS_RD   = 1'b1
    } ds_state_t;

endpackage

// File: rtl/ej32_dstack.sv
// ej32_dstack -- parametrised data stack for the eJ32 arithmetic unit.
// TOS/NOS are registers, deeper entries spill into a register array.
//   clk, rst      : clock, asynchronous active-high reset
//   en, op        : op strobe and dstack_op_t code; accepted when en && !busy_o
//   d_i, k_i      : push/replace/ALU data, PICK position (0 = TOS)
//   t_o, s_o      : TOS and NOS registers (read as 0 when not valid)
//   depth_o       : items on the stack, 0..SS_DEPTH
//   full_o/empty_o: decoded from depth
//   busy_o        : deep PICK in progress (mem read cycle)
//   ovf_o/udf_o   : sticky overflow/underflow, cleared by clr_err
module ej32_dstack
    import ej32_pkg::*;
#(
    parameter int  DSZ      = 32,
    parameter int  SS_DEPTH = 32,
    localparam int SSZ      = $clog2(SS_DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [2:0]     op,
    input  logic [DSZ-1:0] d_i,
    input  logic [SSZ-1:0] k_i,
    output logic [DSZ-1:0] t_o,
    output logic [DSZ-1:0] s_o,
    output logic [SSZ:0]   depth_o,
    output logic           full_o,
    output logic           empty_o,
    output logic           busy_o,
    output logic           ovf_o,
    output logic           udf_o,
    input  logic           clr_err
);

    localparam int MSZ = SS_DEPTH - 2;

    localparam logic [SSZ:0]   D_ONE   = (SSZ+1)'(1);
    localparam logic [SSZ:0]   D_TWO   = (SSZ+1)'(2);
    localparam logic [SSZ:0]   D_THREE = (SSZ+1)'(3);
    localparam logic [SSZ:0]   D_FULL  = (SSZ+1)'(SS_DEPTH);
    localparam logic [SSZ-1:0] I_ONE   = SSZ'(1);
    localparam logic [SSZ-1:0] I_TWO   = SSZ'(2);
    localparam logic [SSZ-1:0] I_THREE = SSZ'(3);

    logic [DSZ-1:0] t_r, s_r, pk_r;
    logic [SSZ:0]   depth_r;
    logic           ovf_r, udf_r;
    ds_state_t      state;
    logic [DSZ-1:0] mem [MSZ];

    // Index arithmetic wraps modulo SS_DEPTH; at depth == SS_DEPTH the low
    // bits are 0, which still yields the right pop index (0 - 3 = MSZ - 1).
    logic [SSZ-1:0] depth_lo, idx_push, idx_fill, idx_pick;
    assign depth_lo = depth_r[SSZ-1:0];
    assign idx_push = depth_lo - I_TWO;
    assign idx_fill = depth_lo - I_THREE;
    assign idx_pick = depth_lo - I_ONE - k_i;

    dstack_op_t op_e;
    assign op_e = dstack_op_t'(op);

    logic           is_full, is_empty, lt_two, k_bad;
    assign is_full  = (depth_r == D_FULL);
    assign is_empty = (depth_r == '0);
    assign lt_two   = (depth_r < D_TWO);
    assign k_bad    = ({1'b0, k_i} >= depth_r);

    // Async read of the entry that becomes NOS after a POP/ALU.
    logic [DSZ-1:0] refill;
    assign refill = (depth_r >= D_THREE) ? mem[idx_fill] : '0;

    logic           push_req, pop_req, swap_req, repl_req, pick_start;
    logic           set_ovf, set_udf;
    logic [DSZ-1:0] push_data, pop_t;

    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        push_req   = 1'b0;
        push_data  = d_i;
        pop_req    = 1'b0;
        pop_t      = s_r;
        swap_req   = 1'b0;
        repl_req   = 1'b0;
        pick_start = 1'b0;
        set_ovf    = 1'b0;
        set_udf    = 1'b0;
        if (state == DS_RD) begin
            // Second PICK cycle: push the latched entry; incoming ops ignored.
            push_req  = 1'b1;
            push_data = pk_r;
        end else if (en) begin
            case (op_e)
                sPUSH: if (is_full) set_ovf = 1'b1; else push_req = 1'b1;
                sPOP:  if (is_empty) set_udf = 1'b1; else pop_req = 1'b1;
                sSWAP: if (lt_two) set_udf = 1'b1; else swap_req = 1'b1;
                sREPL: if (is_empty) set_udf = 1'b1; else repl_req = 1'b1;
                sALU: begin
                    if (lt_two) set_udf = 1'b1;
                    else begin
                        pop_req = 1'b1;
                        pop_t   = d_i;
                    end
                end
                sPICK: begin
                    if (is_full)                set_ovf = 1'b1;
                    else if (k_bad)             set_udf = 1'b1;
                    else if (k_i == '0)         begin push_req = 1'b1; push_data = t_r; end
                    else if (k_i == I_ONE)      begin push_req = 1'b1; push_data = s_r; end
                    else                        pick_start = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_r     <= '0;
            s_r     <= '0;
            pk_r    <= '0;
            depth_r <= '0;
            ovf_r   <= 1'b0;
            udf_r   <= 1'b0;
            state   <= DS_IDLE;
        end else begin
            case (state)
                DS_IDLE: if (pick_start) begin
                    state <= DS_RD;
                    pk_r  <= mem[idx_pick];
                end
                DS_RD:   state <= DS_IDLE;
                default: state <= DS_IDLE;
            endcase

            if (push_req) begin
                s_r     <= t_r;
                t_r     <= push_data;
                depth_r <= depth_r + D_ONE;
            end else if (pop_req) begin
                t_r     <= pop_t;
                s_r     <= refill;
                depth_r <= depth_r - D_ONE;
            end else if (swap_req) begin
                t_r <= s_r;
                s_r <= t_r;
            end else if (repl_req) begin
                t_r <= d_i;
            end

            // A new error in the same cycle as clr_err wins.
            ovf_r <= set_ovf | (ovf_r & ~clr_err);
            udf_r <= set_udf | (udf_r & ~clr_err);
        end
    end

    // NOTE: the spill array has no reset; depth alone marks which entries are valid.
    always_ff @(posedge clk) begin
        if (push_req && depth_r >= D_TWO)
            mem[idx_push] <= s_r;
    end

    assign t_o     = t_r;
    assign s_o     = s_r;
    assign depth_o = depth_r;
    assign full_o  = is_full;
    assign empty_o = is_empty;
    assign busy_o  = (state == DS_RD);
    assign ovf_o   = ovf_r;
    assign udf_o   = udf_r;

endmodule
